// File: rtl/vga_sync_gen_if.sv
// Timing bundle between the VGA sync generator and its consumer.
interface vga_sync_gen_if;
  logic       en;
  logic       pix_tick;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;

  modport master (
    input  en,
    output pix_tick, hsync, vsync, video_on, frame_start, pixel_x, pixel_y
  );

  modport slave (
    output en,
    input  pix_tick, hsync, vsync, video_on, frame_start, pixel_x, pixel_y
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-clock divider, h/v counters and registered
// sync/blanking decode, all updated together on the pixel tick.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  vga_sync_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       px, py;
  logic [9:0]       px_nxt, py_nxt;
  logic             tick_q, hsync_q, vsync_q, video_on_q, frame_start_q;

  always_comb begin
    px_nxt = (px == H_LAST) ? '0 : px + 10'd1;
    py_nxt = py;
    if (px == H_LAST)
      py_nxt = (py == V_LAST) ? '0 : py + 10'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt       <= '0;
      px            <= H_LAST;
      py            <= V_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      tick_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (!vga.en) begin
      // frame_start is a tick-qualified strobe, so it drops with pix_tick
      // rather than holding high through a stall.
      tick_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt       <= '0;
      tick_q        <= 1'b1;
      px            <= px_nxt;
      py            <= py_nxt;
      hsync_q       <= !((px_nxt >= HS_START) && (px_nxt < HS_END));
      vsync_q       <= !((py_nxt >= VS_START) && (py_nxt < VS_END));
      video_on_q    <= (px_nxt < H_ACT) && (py_nxt < V_ACT);
      frame_start_q <= (px_nxt == '0) && (py_nxt == '0);
    end else begin
      div_cnt       <= div_cnt + 1'b1;
      tick_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign vga.pix_tick    = tick_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.frame_start = frame_start_q;
  assign vga.pixel_x     = px;
  assign vga.pixel_y     = py;

endmodule
